// File: rtl/fpdiv_pkg.sv
// Shared types and constants for the fpdiv operand sequencer.
// Holds the FSM state encoding and the request bundle.
package fpdiv_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } fpdiv_seq_state_t;

  typedef struct packed {
    logic [63:0] op1;
    logic [63:0] op2;
    logic [2:0]  rm;
    logic        op_type;
    logic        p;
    logic        oven;
    logic        unen;
  } fpdiv_req_t;

  localparam logic [63:0] FP64_QNAN = 64'h7FF8_0000_0000_0000;
  localparam int FPDIV_FLAGS_W = 5;

endpackage

// File: rtl/fpdiv_seq.sv
// Operand sequencer in front of the multi-cycle fpdiv divider.
// Optional WAIT watchdog enabled by defining FPDIV_SEQ_TIMEOUT_EN.
module fpdiv_seq
  import fpdiv_pkg::*;
#(
  parameter int START_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [63:0]              req_op1,
  input  logic [63:0]              req_op2,
  input  logic [2:0]               req_rm,
  input  logic                     req_op_type,
  input  logic                     req_p,
  input  logic                     req_oven,
  input  logic                     req_unen,
  output logic [63:0]              div_op1,
  output logic [63:0]              div_op2,
  output logic [2:0]               div_rm,
  output logic                     div_op_type,
  output logic                     div_p,
  output logic                     div_oven,
  output logic                     div_unen,
  output logic                     div_start,
  input  logic [63:0]              div_result,
  input  logic [FPDIV_FLAGS_W-1:0] div_flags,
  input  logic                     div_denorm,
  input  logic                     div_done,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [63:0]              rsp_result,
  output logic [FPDIV_FLAGS_W-1:0] rsp_flags,
  output logic                     rsp_denorm,
  output logic                     rsp_timeout,
  output logic                     busy,
  output logic [CNT_W-1:0]         op_count
);

  localparam int SC_W = $clog2(START_CYCLES + 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(START_CYCLES - 1);

  if (START_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("fpdiv_seq: START_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  fpdiv_seq_state_t state;
  fpdiv_req_t       req_q;
  logic [SC_W-1:0]  start_cnt;

  assign div_op1     = req_q.op1;
  assign div_op2     = req_q.op2;
  assign div_rm      = req_q.rm;
  assign div_op_type = req_q.op_type;
  assign div_p       = req_q.p;
  assign div_oven    = req_q.oven;
  assign div_unen    = req_q.unen;

`ifdef FPDIV_SEQ_TIMEOUT_EN
  localparam int WC_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT_CYCLES - 1);

  logic [WC_W-1:0] wait_cnt;
  logic            timeout_q;

  assign rsp_timeout = timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  // Sequencer FSM; handshake/status outputs are registered with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      req_q      <= '0;
      start_cnt  <= '0;
      req_ready  <= 1'b1;
      div_start  <= 1'b0;
      rsp_valid  <= 1'b0;
      busy       <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_denorm <= 1'b0;
      op_count   <= '0;
`ifdef FPDIV_SEQ_TIMEOUT_EN
      wait_cnt   <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_q <= '{op1: req_op1, op2: req_op2,
                       rm: req_rm, op_type: req_op_type,
                       p: req_p, oven: req_oven,
                       unen: req_unen};
            start_cnt <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            div_start <= 1'b1;
            state     <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (start_cnt == SC_LAST) begin
            div_start <= 1'b0;
`ifdef FPDIV_SEQ_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
            state     <= S_WAIT;
          end else begin
            start_cnt <= start_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (div_done) begin
            rsp_result <= div_result;
            rsp_flags  <= div_flags;
            rsp_denorm <= div_denorm;
            rsp_valid  <= 1'b1;
`ifdef FPDIV_SEQ_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
            state      <= S_RESP;
          end
`ifdef FPDIV_SEQ_TIMEOUT_EN
          else if (wait_cnt == WC_LAST) begin
            rsp_result <= FP64_QNAN;
            rsp_flags  <= '0;
            rsp_denorm <= 1'b0;
            rsp_valid  <= 1'b1;
            timeout_q  <= 1'b1;
            state      <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            if (op_count != '1) begin
              op_count <= op_count + 1'b1;
            end
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
